// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: N-way round-robin arbiter with grant parking for a shared resource.
// The owner keeps a registered one-hot grant while requesting; a saturating hold counter flags overlong ownership.
module rr_hold_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 256,
  parameter bit PREEMPT  = 1'b0,
  localparam int IW      = (N > 1) ? $clog2(N) : 1,
  localparam int CW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [0:N-1]  r,
  output logic [0:N-1]  g,
  output logic          owner_vld,
  output logic [IW-1:0] owner_idx,
  output logic [CW-1:0] hold_cnt,
  output logic          hold_err
);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } pick_t;

  state_t        state_r, state_s;
  logic [0:N-1]  g_r, g_s;
  logic [IW-1:0] ptr_r, ptr_s;
  logic [CW-1:0] hold_cnt_r, cnt_s;
  logic          hold_err_r, err_s;
  logic          owner_vld_r;
  logic [IW-1:0] owner_idx_r;
  logic [0:N-1]  others_s;
  pick_t         any_p, oth_p;

  // First set request strictly after 'from', wrapping; 'from' itself is checked last.
  function automatic pick_t pick_next(input logic [0:N-1] req, input logic [IW-1:0] from);
    pick_t         res;
    logic [IW-1:0] pos;
    logic          hit;
    res = '{found: 1'b0, idx: '0};
    for (int k = 1; k <= N; k++) begin
      pos       = IW'((int'(from) + k) % N);
      hit       = req[pos] & ~res.found;
      res.idx   = hit ? pos : res.idx;
      res.found = res.found | hit;
    end
    return res;
  endfunction

  function automatic logic [0:N-1] onehot(input logic [IW-1:0] idx);
    logic [0:N-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next-state decode; while OWNED, ptr_r holds the current owner's index.
  always_comb begin
    state_s          = state_r;
    g_s              = g_r;
    ptr_s            = ptr_r;
    cnt_s            = hold_cnt_r;
    others_s         = r;
    others_s[ptr_r]  = 1'b0;
    any_p            = pick_next(r, ptr_r);
    oth_p            = pick_next(others_s, ptr_r);
    case (state_r)
      IDLE: begin
        if (any_p.found) begin
          state_s = OWNED;
          g_s     = onehot(any_p.idx);
          ptr_s   = any_p.idx;
          cnt_s   = CW'(1);
        end else begin
          g_s   = '0;
          cnt_s = '0;
        end
      end
      OWNED: begin
        if (r[ptr_r]) begin
          if (hold_cnt_r != CW'(MAX_HOLD)) begin
            cnt_s = hold_cnt_r + CW'(1);
          end else if (PREEMPT && oth_p.found) begin
            g_s   = onehot(oth_p.idx);
            ptr_s = oth_p.idx;
            cnt_s = CW'(1);
          end else begin
            cnt_s = hold_cnt_r;
          end
        end else if (any_p.found) begin
          g_s   = onehot(any_p.idx);
          ptr_s = any_p.idx;
          cnt_s = CW'(1);
        end else begin
          state_s = IDLE;
          g_s     = '0;
          cnt_s   = '0;
        end
      end
      default: begin
        state_s = IDLE;
        g_s     = '0;
        ptr_s   = IW'(N - 1);
        cnt_s   = '0;
      end
    endcase
    // Error rises in the same cycle hold_cnt first shows MAX_HOLD.
    err_s = hold_err_r | (cnt_s == CW'(MAX_HOLD));
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      g_r         <= '0;
      ptr_r       <= IW'(N - 1);
      hold_cnt_r  <= '0;
      hold_err_r  <= 1'b0;
      owner_vld_r <= 1'b0;
      owner_idx_r <= '0;
    end else begin
      state_r     <= state_s;
      g_r         <= g_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= cnt_s;
      hold_err_r  <= err_s;
      owner_vld_r <= |g_s;
      owner_idx_r <= (|g_s) ? ptr_s : '0;
    end
  end

  assign g         = g_r;
  assign owner_vld = owner_vld_r;
  assign owner_idx = owner_idx_r;
  assign hold_cnt  = hold_cnt_r;
  assign hold_err  = hold_err_r;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: two instances (parking-only and preempting) share stimulus;
// a reference model feeds expected outputs into queues that a monitor drains every cycle.
module tb_rr_hold_arbiter;
  localparam int N    = 8;
  localparam int MH_A = 256;
  localparam int MH_B = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [0:N-1] r;
  logic [0:N-1] g_a, g_b;
  logic         vld_a, vld_b, err_a, err_b;
  logic [2:0]   idx_a, idx_b;
  logic [8:0]   cnt_a;
  logic [2:0]   cnt_b;

  typedef struct {
    int owner;
    int last;
    int cnt;
    bit err;
  } mstate_t;

  typedef struct {
    logic [0:N-1] g;
    logic         vld;
    int           idx;
    int           cnt;
    logic         err;
  } exp_t;

  exp_t    q_a[$];
  exp_t    q_b[$];
  mstate_t ms_a, ms_b;
  int      total = 0;
  int      bad   = 0;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MH_A), .PREEMPT(1'b0)) u_a (
    .clock(clock), .reset(reset), .r(r), .g(g_a), .owner_vld(vld_a),
    .owner_idx(idx_a), .hold_cnt(cnt_a), .hold_err(err_a)
  );

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MH_B), .PREEMPT(1'b1)) u_b (
    .clock(clock), .reset(reset), .r(r), .g(g_b), .owner_vld(vld_b),
    .owner_idx(idx_b), .hold_cnt(cnt_b), .hold_err(err_b)
  );

  always #5 clock = ~clock;

  function automatic int first_after(input logic [0:N-1] rq, input int from, input int skip);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (rq[i] && i != skip) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic [0:N-1] rq,
                                         input bit rst, input int maxh, input bit pre);
    mstate_t ns;
    int      w;
    ns = s;
    if (rst) begin
      ns = '{owner: -1, last: N - 1, cnt: 0, err: 1'b0};
      return ns;
    end
    if (s.owner < 0) begin
      w = first_after(rq, s.last, -1);
      if (w >= 0) begin ns.owner = w; ns.last = w; ns.cnt = 1; end
      else ns.cnt = 0;
    end else if (rq[s.owner]) begin
      if (s.cnt < maxh) ns.cnt = s.cnt + 1;
      else if (pre) begin
        w = first_after(rq, s.owner, s.owner);
        if (w >= 0) begin ns.owner = w; ns.last = w; ns.cnt = 1; end
      end
    end else begin
      w = first_after(rq, s.owner, -1);
      if (w >= 0) begin ns.owner = w; ns.last = w; ns.cnt = 1; end
      else begin ns.owner = -1; ns.cnt = 0; end
    end
    if (ns.cnt == maxh) ns.err = 1'b1;
    return ns;
  endfunction

  function automatic exp_t to_exp(input mstate_t s);
    exp_t e;
    e.g   = '0;
    e.vld = (s.owner >= 0);
    e.idx = (s.owner >= 0) ? s.owner : 0;
    e.cnt = s.cnt;
    e.err = s.err;
    if (s.owner >= 0) e.g[s.owner] = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [0:N-1] rv, input logic rst);
    r     = rv;
    reset = rst;
    ms_a  = model_next(ms_a, rv, rst, MH_A, 1'b0);
    q_a.push_back(to_exp(ms_a));
    ms_b  = model_next(ms_b, rv, rst, MH_B, 1'b1);
    q_b.push_back(to_exp(ms_b));
    @(posedge clock);
    #1;
  endtask

  // Monitor: every edge, compare both instances against the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_g", int'(g_a), int'(e.g));
        chk("a_vld", int'(vld_a), int'(e.vld));
        chk("a_idx", int'(idx_a), e.idx);
        chk("a_cnt", int'(cnt_a), e.cnt);
        chk("a_err", int'(err_a), int'(e.err));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_g", int'(g_b), int'(e.g));
        chk("b_vld", int'(vld_b), int'(e.vld));
        chk("b_idx", int'(idx_b), e.idx);
        chk("b_cnt", int'(cnt_b), e.cnt);
        chk("b_err", int'(err_b), int'(e.err));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [0:N-1] rv;
    ms_a  = '{owner: -1, last: N - 1, cnt: 0, err: 1'b0};
    ms_b  = '{owner: -1, last: N - 1, cnt: 0, err: 1'b0};
    r     = '0;
    reset = 1'b1;
    step(8'b0000_0000, 1'b1);
    step(8'b0000_0000, 1'b1);
    chk("rst_g", int'(g_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);

    // All request after reset: agent 0 first and parked.
    repeat (5) step(8'b1111_1111, 1'b0);
    chk("t1_g", int'(g_a), int'(8'b1000_0000));
    chk("t1_cnt", int'(cnt_a), 5);

    // Hand-offs 0 -> 2 -> 7 -> idle.
    step(8'b1000_0000, 1'b0);
    step(8'b0010_0001, 1'b0);
    chk("t2_g2", int'(g_a), int'(8'b0010_0000));
    step(8'b0000_0001, 1'b0);
    chk("t2_g7", int'(g_a), int'(8'b0000_0001));
    step(8'b0000_0000, 1'b0);
    chk("t2_idle", int'(g_a), 0);

    // Owner 7 drops as agent 0 arrives: wrap with no bubble.
    step(8'b0000_0001, 1'b0);
    step(8'b0000_0001, 1'b0);
    step(8'b1000_0000, 1'b0);
    chk("t3_wrap", int'(g_a), int'(8'b1000_0000));
    step(8'b0000_0000, 1'b0);

    // Long hold on agent 1 saturates and flags.
    repeat (300) step(8'b0100_0000, 1'b0);
    chk("t4_g", int'(g_a), int'(8'b0100_0000));
    chk("t4_cnt", int'(cnt_a), 256);
    chk("t4_err", int'(err_a), 1);

    // Preempting instance alternates 1 and 3 every MAX_HOLD cycles.
    step(8'b0000_0000, 1'b1);
    repeat (5) step(8'b0101_0000, 1'b0);
    chk("t5_pre", int'(g_b), int'(8'b0001_0000));
    repeat (8) step(8'b0101_0000, 1'b0);

    // Reset mid-grant, then search restarts from agent 0.
    step(8'b0000_0000, 1'b1);
    repeat (3) step(8'b0000_1000, 1'b0);
    step(8'b0000_1000, 1'b1);
    chk("t6_rst", int'(g_a), 0);
    step(8'b0000_1001, 1'b0);
    chk("t6_g", int'(g_a), int'(8'b0000_1000));

    // Random phase with sticky requests so owners park and drop.
    rv = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rv = 8'($urandom());
        if ($urandom_range(0, 2) == 0) rv = rv & 8'($urandom());
      end
      step(rv, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clock);
    #3;
    chk("drain", q_a.size() + q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
